// File: rtl/bram_initiator_pkg.sv
// Shared definitions for the BRAM port initiator.
//   state_t      : controller states (IDLE, RMW_MERGE)
//   byte_merge() : per-byte select between an old and a new word under a mask
//   MASK_ONES    : all-ones byte mask; users slice it to DATA_WIDTH/8 bits
package bram_initiator_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RMW_MERGE = 1'b1
    } state_t;

    // The merge helper works on a fixed maximum width so it can serve any
    // DATA_WIDTH; callers zero-extend inputs and truncate the result.
    localparam int MERGE_MAX_W = 1024;
    localparam int MASK_MAX_W  = MERGE_MAX_W / 8;

    localparam logic [MASK_MAX_W-1:0] MASK_ONES = '1;

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MASK_MAX_W-1:0]  mask
    );
        logic [MERGE_MAX_W-1:0] res;
        for (int i = 0; i < MASK_MAX_W; i++)
            res[i*8 +: 8] = mask[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/bram_port_initiator_if.sv
// Requester-side bus of the BRAM port initiator.
//   req_*  : valid/ready request channel (read, full write, byte-masked write)
//   resp_* : valid/ready read-response channel, data in request order
// master = requester (core side), slave = bram_port_initiator.
interface bram_port_initiator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [DATA_WIDTH/8-1:0] req_byteEnable;
    logic [ADDR_WIDTH-1:0]   req_address;
    logic [DATA_WIDTH-1:0]   req_writeData;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_readData;

    modport master (
        output req_valid, req_write, req_byteEnable, req_address, req_writeData,
        output resp_ready,
        input  req_ready, resp_valid, resp_readData
    );

    modport slave (
        input  req_valid, req_write, req_byteEnable, req_address, req_writeData,
        input  resp_ready,
        output req_ready, resp_valid, resp_readData
    );
endinterface

// File: rtl/bram_resp_fifo.sv
// First-word-fall-through response FIFO.
//   clock, reset : single clock, synchronous active-high reset
//   push/push_data : enqueue one word
//   pop            : dequeue the head (caller guarantees non-empty)
//   count          : occupancy, 0..RESP_DEPTH
//   head           : oldest entry, valid whenever count != 0
// Push and pop in the same cycle are allowed at any occupancy.
module bram_resp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              push,
    input  logic [DATA_WIDTH-1:0]             push_data,
    input  logic                              pop,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   count,
    output logic [DATA_WIDTH-1:0]             head
);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(RESP_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt;

    // Pointers wrap at RESP_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign count = cnt;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/bram_port_initiator.sv
// Drives one port of a dual-port BRAM for a valid/ready requester.
//   clock, reset        : single clock, synchronous active-high reset
//   bus (slave)         : request and buffered read-response channels
//   bram_readEnable     : BRAM read strobe (reads and the RMW pre-read)
//   bram_writeEnable    : BRAM write strobe (full writes and the RMW merge)
//   bram_address        : BRAM word address
//   bram_writeData      : BRAM write data
//   bram_readData       : BRAM read data, valid the cycle after readEnable
//   busy                : work outstanding (RMW, read in flight, or buffered data)
// Byte-masked writes become a read followed one cycle later by a merged write.
module bram_port_initiator
    import bram_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    bram_port_initiator_if.slave  bus,
    output logic                  bram_readEnable,
    output logic                  bram_writeEnable,
    output logic [ADDR_WIDTH-1:0] bram_address,
    output logic [DATA_WIDTH-1:0] bram_writeData,
    input  logic [DATA_WIDTH-1:0] bram_readData,
    output logic                  busy
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [BE_W-1:0] FULL_MASK = MASK_ONES[BE_W-1:0];

    state_t                state_q, state_d;
    logic                  rd_inflight_q;
    logic [ADDR_WIDTH-1:0] rmw_addr_q;
    logic [DATA_WIDTH-1:0] rmw_data_q;
    logic [BE_W-1:0]       rmw_mask_q;

    logic                  fifo_push, fifo_pop;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;

    logic credit_ok, accept, mask_full, mask_zero, rmw_start;

    // Every accepted request reserves a buffer slot: a read accepted now
    // lands in the FIFO two cycles later, possibly while the requester stalls.
    // Credit freed by a pop is only seen the cycle after the pop.
    assign credit_ok = (int'(fifo_count) + int'(rd_inflight_q)) < RESP_DEPTH;

    assign bus.req_ready = !reset && (state_q == IDLE) && credit_ok;
    assign accept        = bus.req_valid && bus.req_ready;
    assign mask_full     = (bus.req_byteEnable == FULL_MASK);
    assign mask_zero     = (bus.req_byteEnable == '0);
    assign rmw_start     = accept && bus.req_write && !mask_full && !mask_zero;

    always_comb begin
        state_d          = state_q;
        bram_readEnable  = 1'b0;
        bram_writeEnable = 1'b0;
        bram_address     = bus.req_address;
        bram_writeData   = bus.req_writeData;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.req_write) begin
                        bram_readEnable = 1'b1;
                    end else if (mask_full) begin
                        bram_writeEnable = 1'b1;
                    end else if (!mask_zero) begin
                        bram_readEnable = 1'b1;
                        state_d         = RMW_MERGE;
                    end
                end
            end
            RMW_MERGE: begin
                // Old word arrives this cycle from the pre-read; a reset here
                // drops the merge so memory stays untouched.
                bram_writeEnable = !reset;
                bram_address     = rmw_addr_q;
                bram_writeData   = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(bram_readData),
                                                          MERGE_MAX_W'(rmw_data_q),
                                                          MASK_MAX_W'(rmw_mask_q)));
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_inflight_q <= accept && !bus.req_write;
        end
    end

    always_ff @(posedge clock) begin
        if (rmw_start) begin
            rmw_addr_q <= bus.req_address;
            rmw_data_q <= bus.req_writeData;
            rmw_mask_q <= bus.req_byteEnable;
        end
    end

    assign fifo_push = rd_inflight_q;
    assign fifo_pop  = bus.resp_valid && bus.resp_ready;

    bram_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESP_DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bram_readData),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign bus.resp_valid    = !reset && (fifo_count != '0);
    assign bus.resp_readData = fifo_head;
    assign busy = !reset && ((state_q != IDLE) || rd_inflight_q || (fifo_count != '0));

endmodule

// File: tb/tb_bram_port_initiator.sv
// Directed bench for bram_port_initiator: a table of requests with
// hand-computed enables and read data, plus sequences for latency,
// RMW timing, backpressure, throughput (RESP_DEPTH=3 instance) and reset.
module tb_bram_port_initiator;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int fifo_viol = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- main DUT, RESP_DEPTH = 2 ----------------
    bram_port_initiator_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();
    logic        bram_re, bram_we, busy;
    logic [7:0]  bram_addr;
    logic [31:0] bram_wd, bram_rd;

    bram_port_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_DEPTH(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus),
        .bram_readEnable  (bram_re),
        .bram_writeEnable (bram_we),
        .bram_address     (bram_addr),
        .bram_writeData   (bram_wd),
        .bram_readData    (bram_rd),
        .busy             (busy)
    );

    // BRAM model: 1-cycle read, new data on read-during-write.
    logic [31:0] mem [256];
    always @(posedge clock) begin
        if (bram_we) mem[bram_addr] <= bram_wd;
        if (bram_re) bram_rd <= bram_we ? bram_wd : mem[bram_addr];
    end

    // ---------------- throughput DUT, RESP_DEPTH = 3 ----------------
    bram_port_initiator_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus3 ();
    logic        re3, we3, busy3;
    logic [7:0]  addr3;
    logic [31:0] wd3, rd3;
    int          we3_seen = 0;
    logic [31:0] last_wd3 = 32'h0;

    bram_port_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_DEPTH(3)) dut3 (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus3),
        .bram_readEnable  (re3),
        .bram_writeEnable (we3),
        .bram_address     (addr3),
        .bram_writeData   (wd3),
        .bram_readData    (rd3),
        .busy             (busy3)
    );

    // Read-only memory image: word a holds C0DE00aa.
    always @(posedge clock) begin
        if (re3) rd3 <= 32'hC0DE_0000 | {24'h0, addr3};
        if (we3) begin
            we3_seen <= we3_seen + 1;
            last_wd3 <= wd3;
        end
    end

    // ---------------- response collectors / FIFO bound monitor ----------------
    logic [31:0] got_q[$];
    logic [31:0] got3_q[$];
    int          got3_cyc[$];

    always @(negedge clock) begin
        if (bus.resp_valid && bus.resp_ready) got_q.push_back(bus.resp_readData);
        if (bus3.resp_valid && bus3.resp_ready) begin
            got3_q.push_back(bus3.resp_readData);
            got3_cyc.push_back(cyc);
        end
        if (dut.fifo_push && !dut.fifo_pop && dut.fifo_count == 2'd2) fifo_viol <= fifo_viol + 1;
        if (dut.fifo_pop && dut.fifo_count == 2'd0) fifo_viol <= fifo_viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; holds the request until accepted, returns at the
    // posedge+1 following acceptance with req_valid dropped.
    task automatic issue(input logic wr, input logic [3:0] be, input logic [7:0] a,
                         input logic [31:0] d, output logic re_o, output logic we_o);
        int w;
        bus.req_valid      = 1'b1;
        bus.req_write      = wr;
        bus.req_byteEnable = be;
        bus.req_address    = a;
        bus.req_writeData  = d;
        w = 0;
        @(negedge clock);
        while (!bus.req_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        if (!bus.req_ready) chk("issue_timeout", 32'(w), 32'd0);
        re_o = bram_re;
        we_o = bram_we;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n, input string name);
        int w;
        w = 0;
        while (got_q.size() < n && w < 50) begin
            @(posedge clock); #1;
            w++;
        end
        chk(name, 32'(got_q.size()), 32'(n));
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        exp_re;
        logic        exp_we;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] exp_q[$];
    logic        re_o, we_o;
    int          base, stalls, seen;

    initial begin
        vecs[0]  = '{1'b1, 4'hF,    8'h30, 32'h5555_5555, 1'b0, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 4'h0,    8'h30, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 4'h0,    8'h30, 32'h0,         1'b1, 1'b0, 32'h5555_5555};
        vecs[3]  = '{1'b1, 4'b1001, 8'h20, 32'hA1BB_CCD2, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 4'h0,    8'h20, 32'h0,         1'b1, 1'b0, 32'hA122_AAD2};
        vecs[5]  = '{1'b1, 4'b0111, 8'h10, 32'h0011_2233, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 4'h0,    8'h10, 32'h0,         1'b1, 1'b0, 32'hDE11_2233};
        vecs[7]  = '{1'b1, 4'hF,    8'h11, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 4'h0,    8'h11, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 4'h0,    8'h10, 32'h0,         1'b1, 1'b0, 32'hDE11_2233};
        vecs[10] = '{1'b1, 4'b1100, 8'h11, 32'h1234_0000, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 4'h0,    8'h11, 32'h0,         1'b1, 1'b0, 32'h1234_F00D};

        bus.req_valid = 1'b1;  bus.req_write = 1'b1;  bus.req_byteEnable = 4'hF;
        bus.req_address = 8'h0; bus.req_writeData = 32'h0; bus.resp_ready = 1'b1;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_byteEnable = 4'h0;
        bus3.req_address = 8'h0; bus3.req_writeData = 32'h0; bus3.resp_ready = 1'b1;
        reset = 1'b1;

        // Reset: outputs forced low even with a request presented.
        @(posedge clock); @(negedge clock);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enables", {bram_re, bram_we}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        bus.req_valid = 1'b0;

        // 1: full write then read; response at accept+2, exactly one.
        issue(1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF, re_o, we_o);
        chk("t1_wr_enables", {re_o, we_o}, 2'b01);
        base = got_q.size();
        issue(1'b0, 4'h0, 8'h10, 32'h0, re_o, we_o);
        chk("t1_rd_enables", {re_o, we_o}, 2'b10);
        @(negedge clock);
        chk("t1_valid_t1", bus.resp_valid, 0);
        @(negedge clock);
        chk("t1_valid_t2", bus.resp_valid, 1);
        chk("t1_data", bus.resp_readData, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("t1_valid_t3", bus.resp_valid, 0);
        chk("t1_one_resp", 32'(got_q.size() - base), 1);
        @(posedge clock); #1;

        // 2: partial write as RMW.
        issue(1'b1, 4'hF, 8'h20, 32'h1122_3344, re_o, we_o);
        issue(1'b1, 4'b0010, 8'h20, 32'h0000_AA00, re_o, we_o);
        chk("t2_preread", {re_o, we_o}, 2'b10);
        @(negedge clock);
        chk("t2_merge_ready", bus.req_ready, 0);
        chk("t2_merge_we", {bram_re, bram_we}, 2'b01);
        chk("t2_merge_addr", bram_addr, 8'h20);
        chk("t2_merge_data", bram_wd, 32'h1122_AA44);
        chk("t2_merge_busy", busy, 1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("t2_ready_back", bus.req_ready, 1);
        @(posedge clock); #1;
        base = got_q.size();
        issue(1'b0, 4'h0, 8'h20, 32'h0, re_o, we_o);
        wait_resp(base + 1, "t2_resp_count");
        if (got_q.size() > base) chk("t2_read_back", got_q[base], 32'h1122_AA44);

        // Table: mixed traffic incl. zero-mask write and RMW variants.
        base = got_q.size();
        foreach (vecs[i]) begin
            issue(vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].data, re_o, we_o);
            chk($sformatf("vec%0d_enables", i), {re_o, we_o}, {vecs[i].exp_re, vecs[i].exp_we});
            if (!vecs[i].wr) exp_q.push_back(vecs[i].exp_rd);
        end
        wait_resp(base + exp_q.size(), "vec_resp_count");
        foreach (exp_q[k])
            if (got_q.size() > base + k)
                chk($sformatf("vec_rd%0d", k), got_q[base + k], exp_q[k]);
        @(posedge clock); #1;

        // 3: credit limit with RESP_DEPTH=2 and a stalled requester.
        for (int i = 0; i < 3; i++)
            issue(1'b1, 4'hF, 8'(8'h40 + i), 32'hA000_0000 + 32'(i), re_o, we_o);
        bus.resp_ready = 1'b0;
        base = got_q.size();
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 8'h40;
        @(negedge clock);
        chk("t3_rdy_a", bus.req_ready, 1);
        @(posedge clock); #1; bus.req_address = 8'h41;
        @(negedge clock);
        chk("t3_rdy_b", bus.req_ready, 1);
        @(posedge clock); #1; bus.req_address = 8'h42;
        @(negedge clock);
        chk("t3_rdy_c_blocked", bus.req_ready, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("t3_rdy_full", bus.req_ready, 0);
        chk("t3_head", bus.resp_readData, 32'hA000_0000);
        @(posedge clock); #1; bus.resp_ready = 1'b1;
        @(negedge clock);
        chk("t3_rdy_pop_cycle", bus.req_ready, 0);
        @(posedge clock); #1; bus.resp_ready = 1'b0;
        @(negedge clock);
        chk("t3_rdy_after_pop", bus.req_ready, 1);
        @(posedge clock); #1; bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
        wait_resp(base + 3, "t3_resp_count");
        for (int k = 0; k < 3; k++)
            if (got_q.size() > base + k)
                chk($sformatf("t3_order%0d", k), got_q[base + k], 32'hA000_0000 + 32'(k));

        // 4: eight back-to-back reads on the RESP_DEPTH=3 instance.
        base = got3_q.size();
        stalls = 0;
        bus3.req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus3.req_address = 8'(i);
            @(negedge clock);
            if (!bus3.req_ready) stalls++;
            @(posedge clock); #1;
        end
        bus3.req_valid = 1'b0;
        chk("t4_stalls", 32'(stalls), 0);
        for (int w = 0; w < 30 && got3_q.size() < base + 8; w++) begin
            @(posedge clock); #1;
        end
        chk("t4_resp_count", 32'(got3_q.size() - base), 8);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            if (got3_q.size() > base + k) begin
                chk($sformatf("t4_data%0d", k), got3_q[base + k], 32'hC0DE_0000 + 32'(k));
                if (got3_cyc[base + k] - got3_cyc[base] != k) stalls++;
            end
        end
        chk("t4_bubbles", 32'(stalls), 0);
        @(negedge clock);
        chk("t4_idle", busy3, 0);
        chk("t4_no_write", 32'(we3_seen), 0);
        chk("t4_no_write_data", last_wd3, 32'h0);
        @(posedge clock); #1;

        // 5: reset during the merge cycle suppresses the write.
        issue(1'b1, 4'hF, 8'h50, 32'h1234_5678, re_o, we_o);
        issue(1'b1, 4'b0001, 8'h50, 32'h0000_00FF, re_o, we_o);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_we_in_reset", bram_we, 0);
        chk("t5_ready_in_reset", bus.req_ready, 0);
        chk("t5_valid_in_reset", bus.resp_valid, 0);
        chk("t5_busy_in_reset", busy, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("t5_ready_reset2", bus.req_ready, 0);
        chk("t5_valid_reset2", bus.resp_valid, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("t5_mem_unchanged", mem[8'h50], 32'h1234_5678);
        base = got_q.size();
        issue(1'b0, 4'h0, 8'h50, 32'h0, re_o, we_o);
        wait_resp(base + 1, "t5_resp_count");
        if (got_q.size() > base) chk("t5_read_back", got_q[base], 32'h1234_5678);
        @(posedge clock); #1;

        // Reset with a read in flight: its data never appears.
        base = got_q.size();
        issue(1'b0, 4'h0, 8'h10, 32'h0, re_o, we_o);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.resp_valid) seen++;
        end
        chk("t5_inflight_dropped", 32'(seen), 0);
        chk("t5_no_resp", 32'(got_q.size() - base), 0);

        chk("fifo_bounds", 32'(fifo_viol), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
